mux: RTL and testbench
======================

MUX -- requirements
Module: mux

Interface
REQ-001 Parameter CHANNELS, default 2, number of input channels; first positional parameter; SHALL be >= 2.
REQ-002 Parameter BUS_SIZE, default 32, width in bits of each channel; second positional parameter; SHALL be >= 1.
REQ-003 clk  input  1  single clock; drives only the optional output register.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 selector  input  CHANNELS  binary-encoded channel index, not one-hot.
REQ-006 data_in  input  CHANNELS*BUS_SIZE  packed channels; channel k occupies bits [BUS_SIZE*k +: BUS_SIZE].
REQ-007 data_out  output  BUS_SIZE  selected channel data.
REQ-008 sel_invalid  output  1  high when selector >= CHANNELS.

Function
REQ-009 With selector = k and k < CHANNELS, data_out SHALL equal data_in[BUS_SIZE*k +: BUS_SIZE].
REQ-010 With selector >= CHANNELS, data_out SHALL be all zeros and sel_invalid SHALL be 1; otherwise sel_invalid SHALL be 0.
REQ-011 Default build (macro absent): data_out and sel_invalid SHALL be purely combinational, with zero-cycle latency; any change on selector or data_in SHALL propagate without a clock edge.
REQ-012 No X or latch SHALL be inferred for any selector value, including values above CHANNELS-1.
REQ-013 Selector comparison SHALL be unsigned and use the full CHANNELS-bit width.
REQ-014 Channel 0 SHALL occupy the least-significant BUS_SIZE bits of data_in.

Reset
REQ-015 Default build: reset and clk SHALL have no functional effect; the outputs follow their inputs even while reset = 1.
REQ-016 With MUX_REG_OUT_EN defined, reset = 1 SHALL force data_out = 0 and sel_invalid = 0 immediately, without waiting for a clock edge.
REQ-017 With MUX_REG_OUT_EN defined, the outputs SHALL hold 0 while reset is high.
REQ-018 With MUX_REG_OUT_EN defined, the first rising clk edge after reset deasserts SHALL load the selected value.

Configuration
REQ-019 Macro MUX_REG_OUT_EN; when defined, data_out and sel_invalid SHALL be registered on the rising edge of clk, giving 1-cycle latency from selector/data_in to output.
REQ-020 Without MUX_REG_OUT_EN, the output behaviour SHALL be per REQ-011.
REQ-021 The port list SHALL be identical in both builds.

Structure
REQ-022 Package mux_pkg SHALL hold the default constants MUX_DEFAULT_CHANNELS = 2 and MUX_DEFAULT_BUS_SIZE = 32.
REQ-023 Selection logic SHALL be a parameterised loop or index slice; there SHALL be no per-CHANNELS hand-written cases.
REQ-024 One sub-module, mux_out_reg (BUS_SIZE+1 bits, async active-high reset to 0), SHALL implement the registered stage and is instantiated only under MUX_REG_OUT_EN.

Verification
REQ-025 CHANNELS=2, BUS_SIZE=32, data_in = {32'hC0DE_0001, 32'hDEAD_BEEF}, selector 0 -> data_out = 32'hDEAD_BEEF after 10 ns; selector 1 -> 32'hC0DE_0001.
REQ-026 CHANNELS=4, BUS_SIZE=32, channel k = 32'h1111_1111*(k+1), selector 0..3 in turn -> data_out = 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, each with sel_invalid = 0.
REQ-027 CHANNELS=2, selector = 2'b10 or 2'b11 -> data_out = 0, sel_invalid = 1; CHANNELS=4, selector = 4'd7 -> data_out = 0, sel_invalid = 1.
REQ-028 Default build, selector fixed at 1 while channel 1 changes to 32'h0000_00FF -> data_out = 32'h0000_00FF with no clk edge, with reset both 0 and 1.
REQ-029 MUX_REG_OUT_EN build: assert reset mid-run -> outputs 0 immediately; release reset, selector = 3 -> data_out = channel 3 exactly one rising edge later.
REQ-030 Every scenario SHALL compare with !== against a golden model recomputed from the same data_in and selector values.

Source files
------------

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - default sizing constants shared by the mux slice
package mux_pkg;
  localparam int MUX_DEFAULT_CHANNELS = 2;
  localparam int MUX_DEFAULT_BUS_SIZE = 32;
endpackage

// File: rtl/mux_out_reg.sv
// rtl/mux_out_reg.sv - output register {sel_invalid, data} for the mux, async active-high clear
module mux_out_reg import mux_pkg::*; #(
  parameter int BUS_SIZE = MUX_DEFAULT_BUS_SIZE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BUS_SIZE:0]   d,
  output logic [BUS_SIZE:0]   q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/mux.sv
// rtl/mux.sv - binary-selected N-channel mux with out-of-range flag
// MUX_REG_OUT_EN: register data_out/sel_invalid (1-cycle latency); otherwise purely combinational.
module mux import mux_pkg::*; #(
  parameter int CHANNELS = MUX_DEFAULT_CHANNELS,
  parameter int BUS_SIZE = MUX_DEFAULT_BUS_SIZE
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          selector,
  input  logic [CHANNELS*BUS_SIZE-1:0] data_in,
  output logic [BUS_SIZE-1:0]          data_out,
  output logic                         sel_invalid
);

  localparam logic [CHANNELS-1:0] LAST_SEL = CHANNELS'(CHANNELS - 1);

  logic [BUS_SIZE-1:0] mux_data;
  logic                mux_invalid;

  assign mux_invalid = (selector > LAST_SEL);

  // Unmatched selector values leave the zero default, so no latch and no X.
  always_comb begin
    mux_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (selector == CHANNELS'(k)) begin
        mux_data = data_in[BUS_SIZE*k +: BUS_SIZE];
      end
    end
  end

`ifdef MUX_REG_OUT_EN
  logic [BUS_SIZE:0] out_q;

  mux_out_reg #(
    .BUS_SIZE(BUS_SIZE)
  ) u_out_reg (
    .clk   (clk),
    .reset (reset),
    .d     ({mux_invalid, mux_data}),
    .q     (out_q)
  );

  assign {sel_invalid, data_out} = out_q;
`else
  // clk and reset are kept on the port list so both builds share one interface.
  logic unused_ctrl;
  assign unused_ctrl = clk ^ reset;

  assign data_out    = mux_data;
  assign sel_invalid = mux_invalid;
`endif

endmodule

// File: tb/tb_mux.sv
// tb/tb_mux.sv - self-checking bench for mux (default and MUX_REG_OUT_EN builds)
module tb_mux;

  logic         clk = 1'b0;
  logic         reset;

  logic [1:0]   sel2;
  logic [63:0]  din2;
  logic [31:0]  dout2;
  logic         inv2;

  logic [2:0]   sel3;
  logic [23:0]  din3;
  logic [7:0]   dout3;
  logic         inv3;

  logic [3:0]   sel4;
  logic [127:0] din4;
  logic [31:0]  dout4;
  logic         inv4;

  logic [31:0]  c2[2];
  logic [31:0]  c3[3];
  logic [31:0]  c4[4];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          inst;
    logic [3:0]  sel;
    logic [31:0] exp_data;
    logic        exp_inv;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  mux #(.CHANNELS(2), .BUS_SIZE(32)) u_mux2 (
    .clk(clk), .reset(reset), .selector(sel2), .data_in(din2),
    .data_out(dout2), .sel_invalid(inv2)
  );

  mux #(.CHANNELS(3), .BUS_SIZE(8)) u_mux3 (
    .clk(clk), .reset(reset), .selector(sel3), .data_in(din3),
    .data_out(dout3), .sel_invalid(inv3)
  );

  mux #(.CHANNELS(4), .BUS_SIZE(32)) u_mux4 (
    .clk(clk), .reset(reset), .selector(sel4), .data_in(din4),
    .data_out(dout4), .sel_invalid(inv4)
  );

  task automatic drive();
    din2 = {c2[1], c2[0]};
    din3 = {c3[2][7:0], c3[1][7:0], c3[0][7:0]};
    din4 = {c4[3], c4[2], c4[1], c4[0]};
  endtask

  task automatic settle();
`ifdef MUX_REG_OUT_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Golden model: the chosen channel's value if in range, else zero.
  function automatic logic [31:0] model_data(input int inst, input int unsigned sel);
    if (sel >= inst) return 32'h0;
    case (inst)
      2:       return c2[sel];
      3:       return {24'h0, c3[sel][7:0]};
      default: return c4[sel];
    endcase
  endfunction

  function automatic logic model_inv(input int inst, input int unsigned sel);
    return (sel >= inst);
  endfunction

  initial begin
    vecs = '{
      '{2, 4'd0,  32'hDEAD_BEEF, 1'b0},
      '{2, 4'd1,  32'hC0DE_0001, 1'b0},
      '{2, 4'd2,  32'h0,         1'b1},
      '{2, 4'd3,  32'h0,         1'b1},
      '{4, 4'd0,  32'h1111_1111, 1'b0},
      '{4, 4'd1,  32'h2222_2222, 1'b0},
      '{4, 4'd2,  32'h3333_3333, 1'b0},
      '{4, 4'd3,  32'h4444_4444, 1'b0},
      '{4, 4'd4,  32'h0,         1'b1},
      '{4, 4'd7,  32'h0,         1'b1},
      '{4, 4'd15, 32'h0,         1'b1}
    };

    reset = 1'b1;
    sel2 = '0;
    sel3 = '0;
    sel4 = '0;
    c2[0] = 32'hDEAD_BEEF;
    c2[1] = 32'hC0DE_0001;
    for (int k = 0; k < 4; k++) c4[k] = 32'h1111_1111 * (k + 1);
    for (int k = 0; k < 3; k++) c3[k] = $urandom;
    drive();

    #2;
`ifdef MUX_REG_OUT_EN
    check("reset_dout2", dout2, 32'h0);
    check("reset_inv2", {31'h0, inv2}, 32'h0);
    check("reset_dout4", dout4, 32'h0);
    @(posedge clk);
    #1;
    check("reset_hold_dout2", dout2, 32'h0);
    check("reset_hold_dout4", dout4, 32'h0);
`else
    check("reset_follow_dout2", dout2, model_data(2, sel2));
    check("reset_follow_dout4", dout4, model_data(4, sel4));
    check("reset_follow_inv2", {31'h0, inv2}, 32'h0);
`endif
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].inst == 2) sel2 = vecs[i].sel[1:0];
      else sel4 = vecs[i].sel;
      settle();
      check($sformatf("vec%0d_data", i), (vecs[i].inst == 2) ? dout2 : dout4, vecs[i].exp_data);
      check($sformatf("vec%0d_inv", i), {31'h0, (vecs[i].inst == 2) ? inv2 : inv4},
            {31'h0, vecs[i].exp_inv});
    end

`ifndef MUX_REG_OUT_EN
    // Data change on the selected channel must reach the output between clock edges.
    sel2 = 2'd1;
    for (int r = 0; r < 2; r++) begin
      reset = r[0];
      @(negedge clk);
      c2[1] = 32'h1234_5678;
      drive();
      #1;
      check($sformatf("comb_pre_r%0d", r), dout2, 32'h1234_5678);
      c2[1] = 32'h0000_00FF;
      drive();
      #1;
      check($sformatf("comb_post_r%0d", r), dout2, 32'h0000_00FF);
    end
    reset = 1'b0;
`else
    // Mid-cycle reset clears outputs at once; release then loads on the next edge.
    sel4 = 4'd7;
    settle();
    check("pre_reset_inv4", {31'h0, inv4}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_reset_dout4", dout4, 32'h0);
    check("async_reset_inv4", {31'h0, inv4}, 32'h0);
    @(posedge clk);
    #1;
    check("held_reset_dout4", dout4, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    sel4 = 4'd3;
    #1;
    check("released_no_edge_dout4", dout4, 32'h0);
    @(posedge clk);
    #1;
    check("first_edge_dout4", dout4, c4[3]);
    check("first_edge_inv4", {31'h0, inv4}, 32'h0);
`endif

    for (int i = 0; i < 100; i++) begin
      c2[0] = $urandom; c2[1] = $urandom;
      for (int k = 0; k < 3; k++) c3[k] = $urandom;
      for (int k = 0; k < 4; k++) c4[k] = $urandom;
      sel2 = 2'($urandom_range(0, 3));
      sel3 = 3'($urandom_range(0, 7));
      sel4 = 4'($urandom_range(0, 15));
      drive();
      settle();
      check($sformatf("rnd%0d_dout2", i), dout2, model_data(2, sel2));
      check($sformatf("rnd%0d_inv2", i), {31'h0, inv2}, {31'h0, model_inv(2, sel2)});
      check($sformatf("rnd%0d_dout3", i), {24'h0, dout3}, model_data(3, sel3));
      check($sformatf("rnd%0d_inv3", i), {31'h0, inv3}, {31'h0, model_inv(3, sel3)});
      check($sformatf("rnd%0d_dout4", i), dout4, model_data(4, sel4));
      check($sformatf("rnd%0d_inv4", i), {31'h0, inv4}, {31'h0, model_inv(4, sel4)});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
